// File: rtl/pwm_capture.sv
// pwm_capture: measures high time, period and 12-bit duty ratio of a PWM input.
// Results publish after a 12-step restoring divide; loss of edges sets signal_lost.
`timescale 1ns/1ps
module pwm_capture #(
    parameter int CNT_WIDTH = 16,
    parameter int TIMEOUT   = 50000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 capture_enable,
    input  logic                 pwm_in,
    output logic [CNT_WIDTH-1:0] high_count,
    output logic [CNT_WIDTH-1:0] period_count,
    output logic [11:0]          duty_ratio,
    output logic                 sample_valid,
    output logic                 signal_lost
);

    localparam logic [CNT_WIDTH-1:0] TMO     = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] hi_q, hi_d;
    logic                 pwm_sync1, pwm_s, pwm_d;
    logic                 rise, fall;
    logic                 start, timeout;
    logic [CNT_WIDTH-1:0] cnt_inc;

    logic                 busy;
    logic [3:0]           step;
    logic [CNT_WIDTH-1:0] rem_q, den_q, num_q;
    logic [11:0]          quo_q;
    logic                 sat_q;
    logic [CNT_WIDTH:0]   sh, sub;
    logic                 ge;
    logic [CNT_WIDTH-1:0] rem_n;
    logic [11:0]          quo_n;
    logic                 last_step;

    assign rise    = pwm_s & ~pwm_d;
    assign fall    = ~pwm_s & pwm_d;
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + ONE;

    // Two-flop synchronizer plus one delay flop for edge detection
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pwm_sync1 <= 1'b0;
            pwm_s     <= 1'b0;
            pwm_d     <= 1'b0;
        end else begin
            pwm_sync1 <= pwm_in;
            pwm_s     <= pwm_sync1;
            pwm_d     <= pwm_s;
        end
    end

    // Capture FSM state, shared counter and latched high time
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
        end
    end

    // Next state: edges take priority over timeout so an exact-TIMEOUT period still measures
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        start   = 1'b0;
        timeout = 1'b0;
        if (!capture_enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d = HIGH;
                        cnt_d   = ONE;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        hi_d    = cnt_q;
                        state_d = LOW;
                        cnt_d   = cnt_inc;
                    end else if (cnt_q == TMO) begin
                        timeout = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                LOW: begin
                    if (rise) begin
                        start   = ~busy;
                        state_d = HIGH;
                        cnt_d   = ONE;
                    end else if (cnt_q == TMO) begin
                        timeout = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign sh        = {rem_q, 1'b0};
    assign sub       = sh - {1'b0, den_q};
    assign ge        = (sh >= {1'b0, den_q});
    assign rem_n     = ge ? sub[CNT_WIDTH-1:0] : sh[CNT_WIDTH-1:0];
    assign quo_n     = {quo_q[10:0], ge};
    assign last_step = (step == 4'd11);

    // Restoring divider: hi*4096/period, one quotient bit per cycle, then publish
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy         <= 1'b0;
            step         <= '0;
            rem_q        <= '0;
            den_q        <= '0;
            num_q        <= '0;
            quo_q        <= '0;
            sat_q        <= 1'b0;
            high_count   <= '0;
            period_count <= '0;
            duty_ratio   <= '0;
            sample_valid <= 1'b0;
        end else if (!capture_enable) begin
            busy         <= 1'b0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (start) begin
                busy  <= 1'b1;
                step  <= '0;
                rem_q <= hi_q;
                den_q <= cnt_q;
                num_q <= hi_q;
                quo_q <= '0;
                sat_q <= (hi_q >= cnt_q);
            end else if (busy) begin
                rem_q <= rem_n;
                quo_q <= quo_n;
                step  <= step + 4'd1;
                if (last_step) begin
                    busy         <= 1'b0;
                    high_count   <= num_q;
                    period_count <= den_q;
                    duty_ratio   <= sat_q ? 12'd4095 : quo_n;
                    sample_valid <= 1'b1;
                end
            end
        end
    end

    // Loss flag: timeout wins over a same-cycle publish, which otherwise clears it
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            signal_lost <= 1'b0;
        end else if (!capture_enable) begin
            signal_lost <= 1'b0;
        end else if (timeout) begin
            signal_lost <= 1'b1;
        end else if (busy && last_step) begin
            signal_lost <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed checks of pwm_capture measurement, timing,
// timeout, sample dropping, reset mid-divide and enable gating.
`timescale 1ns/1ps
module tb_pwm_capture;

    localparam int T = 5000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        capture_enable = 1'b0;
    logic        pwm_in = 1'b0;
    logic [15:0] high_count;
    logic [15:0] period_count;
    logic [11:0] duty_ratio;
    logic        sample_valid;
    logic        signal_lost;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int nvalid = 0;
    int last_valid_cyc = -1;
    int prev_d = -1;
    int min_gap = 1000000;
    bit phase_d = 1'b0;
    int rc;
    int n0;

    pwm_capture #(.CNT_WIDTH(16), .TIMEOUT(T)) dut (
        .clock(clock),
        .reset(reset),
        .capture_enable(capture_enable),
        .pwm_in(pwm_in),
        .high_count(high_count),
        .period_count(period_count),
        .duty_ratio(duty_ratio),
        .sample_valid(sample_valid),
        .signal_lost(signal_lost)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (sample_valid === 1'b1) begin
            nvalid++;
            last_valid_cyc = cyc;
            if (phase_d) begin
                if (prev_d >= 0 && cyc - prev_d < min_gap)
                    min_gap = cyc - prev_d;
                prev_d = cyc;
                chk("d_high", 32'(high_count), 4);
                chk("d_period", 32'(period_count), 8);
                chk("d_duty", 32'(duty_ratio), 2048);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse(input int hi, input int lo);
        pwm_in = 1'b1;
        tick(hi);
        pwm_in = 1'b0;
        tick(lo);
    endtask

    initial begin
        #2 reset = 1'b1;
        tick(3);
        chk("rst_high", 32'(high_count), 0);
        chk("rst_period", 32'(period_count), 0);
        chk("rst_duty", 32'(duty_ratio), 0);
        chk("rst_valid", 32'(sample_valid), 0);
        chk("rst_lost", 32'(signal_lost), 0);
        reset = 1'b0;
        tick(2);
        capture_enable = 1'b1;
        tick(2);

        // 1000/500 wave
        n0 = nvalid;
        repeat (5) pulse(500, 500);
        pwm_in = 1'b1;
        rc = cyc;
        tick(20);
        chk("a_count", 32'(nvalid - n0), 5);
        chk("a_latency", 32'(last_valid_cyc - rc), 15);
        chk("a_high", 32'(high_count), 500);
        chk("a_period", 32'(period_count), 1000);
        chk("a_duty", 32'(duty_ratio), 2048);

        // 4000 period, 125 high then 3999 high
        tick(105);
        pwm_in = 1'b0;
        tick(3875);
        pwm_in = 1'b1;
        rc = cyc;
        tick(20);
        chk("b_high", 32'(high_count), 125);
        chk("b_period", 32'(period_count), 4000);
        chk("b_duty", 32'(duty_ratio), 128);
        tick(3979);
        pwm_in = 1'b0;
        tick(1);
        pwm_in = 1'b1;
        rc = cyc;
        tick(20);
        chk("b2_high", 32'(high_count), 3999);
        chk("b2_period", 32'(period_count), 4000);
        chk("b2_duty", 32'(duty_ratio), 4094);

        // Timeout with pwm held high
        tick(T + 2 - 20);
        chk("c_lost_early", 32'(signal_lost), 0);
        tick(1);
        chk("c_lost", 32'(signal_lost), 1);
        chk("c_hold_high", 32'(high_count), 3999);
        chk("c_hold_period", 32'(period_count), 4000);
        chk("c_hold_duty", 32'(duty_ratio), 4094);
        tick(7);
        pwm_in = 1'b0;
        tick(10);
        pulse(500, 500);
        n0 = nvalid;
        pwm_in = 1'b1;
        rc = cyc;
        tick(14);
        chk("c_lost_hold", 32'(signal_lost), 1);
        chk("c_no_valid", 32'(nvalid - n0), 0);
        tick(1);
        chk("c_valid", 32'(sample_valid), 1);
        chk("c_lost_clr", 32'(signal_lost), 0);
        chk("c_high", 32'(high_count), 500);
        chk("c_period", 32'(period_count), 1000);
        chk("c_duty", 32'(duty_ratio), 2048);

        // Period 8: every other sample dropped
        capture_enable = 1'b0;
        pwm_in = 1'b0;
        tick(5);
        capture_enable = 1'b1;
        tick(2);
        n0 = nvalid;
        phase_d = 1'b1;
        repeat (20) pulse(4, 4);
        tick(20);
        phase_d = 1'b0;
        chk("d_count", 32'(nvalid - n0), 10);
        chk("d_gap", 32'(min_gap), 16);

        // Reset mid-divide
        capture_enable = 1'b0;
        tick(2);
        capture_enable = 1'b1;
        tick(2);
        pulse(500, 500);
        pwm_in = 1'b1;
        rc = cyc;
        tick(8);
        reset = 1'b1;
        #1;
        chk("e_high", 32'(high_count), 0);
        chk("e_period", 32'(period_count), 0);
        chk("e_duty", 32'(duty_ratio), 0);
        chk("e_valid", 32'(sample_valid), 0);
        chk("e_lost", 32'(signal_lost), 0);
        pwm_in = 1'b0;
        tick(3);
        reset = 1'b0;
        n0 = nvalid;
        tick(30);
        chk("e_no_valid", 32'(nvalid - n0), 0);
        chk("e_high_zero", 32'(high_count), 0);
        pulse(300, 700);
        pulse(300, 700);
        pwm_in = 1'b1;
        rc = cyc;
        tick(20);
        chk("e_count", 32'(nvalid - n0), 2);
        chk("e2_high", 32'(high_count), 300);
        chk("e2_period", 32'(period_count), 1000);
        chk("e2_duty", 32'(duty_ratio), 1228);

        // Enable dropped mid-period after a timeout
        tick(T + 5);
        chk("f_lost", 32'(signal_lost), 1);
        pwm_in = 1'b0;
        tick(10);
        pwm_in = 1'b1;
        tick(100);
        capture_enable = 1'b0;
        n0 = nvalid;
        tick(1);
        chk("f_lost_clr", 32'(signal_lost), 0);
        tick(199);
        pwm_in = 1'b0;
        tick(700);
        pwm_in = 1'b1;
        tick(50);
        pwm_in = 1'b0;
        tick(10);
        chk("f_no_valid", 32'(nvalid - n0), 0);
        chk("f_lost_off", 32'(signal_lost), 0);
        capture_enable = 1'b1;
        tick(5);
        pulse(250, 750);
        chk("f_first_none", 32'(nvalid - n0), 0);
        pwm_in = 1'b1;
        rc = cyc;
        tick(14);
        chk("f_not_yet", 32'(nvalid - n0), 0);
        tick(1);
        chk("f_valid", 32'(sample_valid), 1);
        chk("f_high", 32'(high_count), 250);
        chk("f_period", 32'(period_count), 1000);
        chk("f_duty", 32'(duty_ratio), 1024);
        tick(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
